// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, winner codes, default timing constants.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ROUND_INIT = 3'd1,
        ST_COUNTDOWN  = 3'd2,
        ST_FIGHT      = 3'd3,
        ST_ROUND_END  = 3'd4,
        ST_MATCH_OVER = 3'd5
    } game_state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam int unsigned DEF_TICKS_PER_SEC     = 20;
    localparam int unsigned DEF_ROUND_SECONDS     = 60;
    localparam int unsigned DEF_COUNTDOWN_SECONDS = 3;
    localparam int unsigned DEF_KO_HOLD_TICKS     = 40;
    localparam int unsigned DEF_WINS_TO_MATCH     = 2;

    localparam int unsigned SEC_W    = 7;
    localparam int unsigned HEALTH_W = 9;
    localparam int unsigned WINS_W   = 2;
    localparam int unsigned ROUND_W  = 3;

    localparam logic [ROUND_W-1:0] ROUND_MAX = 3'd7;

endpackage

// File: rtl/sec_timer.sv
// Tick prescaler plus loadable seconds down-counter shared by countdown and fight.
module sec_timer
    import game_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    output logic [SEC_W-1:0] secs,
    output logic             sec_c,
    output logic             zero_next_c
);

    localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0] secs_q, secs_d;

    // One-second boundary: last tick of the current prescaler period.
    assign sec_c       = en && tick && (presc_q == PRE_W'(TICKS_PER_SEC - 1));
    // Next decrement lands on zero (or the counter is already empty).
    assign zero_next_c = (secs_q <= SEC_W'(1));
    assign secs        = secs_q;

    // Prescaler advance/clear and seconds load/decrement.
    always_comb begin
        presc_d = presc_q;
        secs_d  = secs_q;
        if (clear) begin
            presc_d = '0;
        end else if (en && tick) begin
            presc_d = sec_c ? '0 : presc_q + PRE_W'(1);
        end
        if (load) begin
            secs_d = load_val;
        end else if (sec_c && (secs_q != '0)) begin
            secs_d = secs_q - SEC_W'(1);
        end
    end

    // Timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            secs_q  <= '0;
        end else begin
            presc_q <= presc_d;
            secs_q  <= secs_d;
        end
    end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencing for a two-player fighting game.
module match_controller
    import game_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC     = DEF_TICKS_PER_SEC,
    parameter int unsigned ROUND_SECONDS     = DEF_ROUND_SECONDS,
    parameter int unsigned COUNTDOWN_SECONDS = DEF_COUNTDOWN_SECONDS,
    parameter int unsigned KO_HOLD_TICKS     = DEF_KO_HOLD_TICKS,
    parameter int unsigned WINS_TO_MATCH     = DEF_WINS_TO_MATCH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic [HEALTH_W-1:0] health_1,
    input  logic [HEALTH_W-1:0] health_2,
    output logic [2:0]          game_state,
    output logic                input_enable,
    output logic                round_reset,
    output logic [SEC_W-1:0]    timer_sec,
    output logic [WINS_W-1:0]   wins_1,
    output logic [WINS_W-1:0]   wins_2,
    output logic [ROUND_W-1:0]  round_num,
    output logic [1:0]          winner
);

    localparam int unsigned HOLD_W = (KO_HOLD_TICKS > 1) ? $clog2(KO_HOLD_TICKS) : 1;

    game_state_e         state_q, state_d;
    logic                start_q;
    logic                round_reset_q, round_reset_d;
    logic [WINS_W-1:0]   wins_1_q, wins_1_d, wins_2_q, wins_2_d;
    logic [ROUND_W-1:0]  round_num_q, round_num_d;
    logic [1:0]          winner_q, winner_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic                start_press;
    logic                tmr_en, tmr_load, tmr_clear;
    logic [SEC_W-1:0]    tmr_load_val;
    logic                sec_c, zero_next_c;
    logic [1:0]          result;

    assign start_press = start && !start_q;
    // Every state entry restarts the prescaler so each second is a full period.
    assign tmr_clear   = (state_d != state_q);

    sec_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_sec_timer (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .en          (tmr_en),
        .clear       (tmr_clear),
        .load        (tmr_load),
        .load_val    (tmr_load_val),
        .secs        (timer_sec),
        .sec_c       (sec_c),
        .zero_next_c (zero_next_c)
    );

    // Next-state, scoring and timer control.
    always_comb begin
        state_d      = state_q;
        wins_1_d     = wins_1_q;
        wins_2_d     = wins_2_q;
        round_num_d  = round_num_q;
        winner_d     = winner_q;
        hold_d       = hold_q;
        tmr_en       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        result       = WIN_NONE;

        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    wins_1_d    = '0;
                    wins_2_d    = '0;
                    round_num_d = ROUND_W'(1);
                    winner_d    = WIN_NONE;
                    state_d     = ST_ROUND_INIT;
                end
            end
            ST_ROUND_INIT: begin
                tmr_load     = 1'b1;
                tmr_load_val = SEC_W'(COUNTDOWN_SECONDS);
                state_d      = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                tmr_en = 1'b1;
                if (sec_c && zero_next_c) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = SEC_W'(ROUND_SECONDS);
                    state_d      = ST_FIGHT;
                end
            end
            ST_FIGHT: begin
                tmr_en = 1'b1;
                if (tick) begin
                    if ((health_1 == '0) && (health_2 == '0)) begin
                        result = WIN_DRAW;
                    end else if (health_1 == '0) begin
                        result = WIN_P2;
                    end else if (health_2 == '0) begin
                        result = WIN_P1;
                    end else if (sec_c && zero_next_c) begin
                        if (health_1 > health_2) begin
                            result = WIN_P1;
                        end else if (health_2 > health_1) begin
                            result = WIN_P2;
                        end else begin
                            result = WIN_DRAW;
                        end
                    end
                end
                if (result != WIN_NONE) begin
                    winner_d = result;
                    hold_d   = '0;
                    state_d  = ST_ROUND_END;
                    if (result == WIN_P1) begin
                        wins_1_d = wins_1_q + WINS_W'(1);
                    end
                    if (result == WIN_P2) begin
                        wins_2_d = wins_2_q + WINS_W'(1);
                    end
                end
            end
            ST_ROUND_END: begin
                if (tick) begin
                    if (hold_q == HOLD_W'(KO_HOLD_TICKS - 1)) begin
                        if ((wins_1_q == WINS_W'(WINS_TO_MATCH)) ||
                            (wins_2_q == WINS_W'(WINS_TO_MATCH))) begin
                            state_d = ST_MATCH_OVER;
                        end else begin
                            round_num_d = (round_num_q == ROUND_MAX) ? ROUND_MAX
                                                                     : round_num_q + ROUND_W'(1);
                            state_d     = ST_ROUND_INIT;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_MATCH_OVER: begin
                if (start_press) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        round_reset_d = (state_d == ST_ROUND_INIT);
    end

    // State and scoreboard registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            round_reset_q <= 1'b0;
            wins_1_q      <= '0;
            wins_2_q      <= '0;
            round_num_q   <= '0;
            winner_q      <= WIN_NONE;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            round_reset_q <= round_reset_d;
            wins_1_q      <= wins_1_d;
            wins_2_q      <= wins_2_d;
            round_num_q   <= round_num_d;
            winner_q      <= winner_d;
            hold_q        <= hold_d;
        end
    end

    assign game_state   = state_q;
    assign input_enable = (state_q == ST_FIGHT);
    assign round_reset  = round_reset_q;
    assign wins_1       = wins_1_q;
    assign wins_2       = wins_2_q;
    assign round_num    = round_num_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: tick-count model plus directed round scenarios.
module tb_match_controller;
    import game_pkg::*;

    localparam int TPS  = 20;
    localparam int RSEC = 60;
    localparam int CSEC = 3;
    localparam int KO   = 40;
    localparam int WTM  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [8:0] health_1 = 9'd100;
    logic [8:0] health_2 = 9'd100;
    logic [2:0] game_state;
    logic       input_enable;
    logic       round_reset;
    logic [6:0] timer_sec;
    logic [1:0] wins_1, wins_2;
    logic [2:0] round_num;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    match_controller dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .health_1     (health_1),
        .health_2     (health_2),
        .game_state   (game_state),
        .input_enable (input_enable),
        .round_reset  (round_reset),
        .timer_sec    (timer_sec),
        .wins_1       (wins_1),
        .wins_2       (wins_2),
        .round_num    (round_num),
        .winner       (winner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks ticks spent in the current state; timer derived by division.
    game_state_e m_state = ST_IDLE, n_state;
    int  m_ticks = 0, m_base = 0, m_w1 = 0, m_w2 = 0, m_rnd = 0, m_win = 0;
    int  n_ticks, n_base, n_w1, n_w2, n_rnd, n_win, res;
    bit  m_prev = 1'b0;
    bit  press;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= ST_IDLE;
            m_ticks <= 0;
            m_base  <= 0;
            m_w1    <= 0;
            m_w2    <= 0;
            m_rnd   <= 0;
            m_win   <= 0;
            m_prev  <= 1'b0;
        end else begin
            n_state = m_state; n_ticks = m_ticks; n_base = m_base;
            n_w1 = m_w1; n_w2 = m_w2; n_rnd = m_rnd; n_win = m_win;
            press = start && !m_prev;
            res = 0;
            case (m_state)
                ST_IDLE: if (press) begin
                    n_state = ST_ROUND_INIT; n_w1 = 0; n_w2 = 0; n_rnd = 1; n_win = 0;
                end
                ST_ROUND_INIT: begin
                    n_state = ST_COUNTDOWN; n_base = CSEC; n_ticks = 0;
                end
                ST_COUNTDOWN: if (tick) begin
                    n_ticks = m_ticks + 1;
                    if (n_ticks == CSEC * TPS) begin
                        n_state = ST_FIGHT; n_base = RSEC; n_ticks = 0;
                    end
                end
                ST_FIGHT: if (tick) begin
                    n_ticks = m_ticks + 1;
                    if (health_1 == 0 && health_2 == 0) res = 3;
                    else if (health_1 == 0) res = 2;
                    else if (health_2 == 0) res = 1;
                    else if (n_ticks == RSEC * TPS)
                        res = (health_1 > health_2) ? 1 : (health_2 > health_1) ? 2 : 3;
                    if (res != 0) begin
                        n_win = res;
                        if (res == 1) n_w1 = m_w1 + 1;
                        if (res == 2) n_w2 = m_w2 + 1;
                        n_state = ST_ROUND_END; n_ticks = 0;
                    end
                end
                ST_ROUND_END: if (tick) begin
                    n_ticks = m_ticks + 1;
                    if (n_ticks == KO) begin
                        n_ticks = 0;
                        if (m_w1 == WTM || m_w2 == WTM) n_state = ST_MATCH_OVER;
                        else begin
                            n_rnd = (m_rnd >= 7) ? 7 : m_rnd + 1;
                            n_state = ST_ROUND_INIT;
                        end
                    end
                end
                ST_MATCH_OVER: if (press) n_state = ST_IDLE;
                default: n_state = ST_IDLE;
            endcase
            m_state <= n_state; m_ticks <= n_ticks; m_base <= n_base;
            m_w1 <= n_w1; m_w2 <= n_w2; m_rnd <= n_rnd; m_win <= n_win;
            m_prev <= start;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("state", 32'(game_state), 32'(m_state));
            check("input_enable", 32'(input_enable), 32'(m_state == ST_FIGHT));
            check("round_reset", 32'(round_reset), 32'(m_state == ST_ROUND_INIT));
            check("wins_1", 32'(wins_1), 32'(m_w1));
            check("wins_2", 32'(wins_2), 32'(m_w2));
            check("round_num", 32'(round_num), 32'(m_rnd));
            check("winner", 32'(winner), 32'(m_win));
            if (m_state == ST_COUNTDOWN || m_state == ST_FIGHT)
                check("timer_sec", 32'(timer_sec), 32'(m_base - m_ticks / TPS));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            cyc();
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) cyc();
        cmp_on = 1'b1;
        @(negedge clk);
        check("lit_rst_state", 32'(game_state), 32'd0);
        check("lit_rst_timer", 32'(timer_sec), 32'd0);
        check("lit_rst_round", 32'(round_num), 32'd0);
        check("lit_rst_rr", 32'(round_reset), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        cyc();

        // Match 1, round 1: countdown, ignored press, P1 KO.
        press_start();
        @(negedge clk);
        check("lit_init_state", 32'(game_state), 32'd1);
        check("lit_init_rr", 32'(round_reset), 32'd1);
        cyc();
        @(negedge clk);
        check("lit_cd_state", 32'(game_state), 32'd2);
        check("lit_cd_timer", 32'(timer_sec), 32'd3);
        ticks(59);
        @(negedge clk);
        check("lit_cd_last_state", 32'(game_state), 32'd2);
        check("lit_cd_last_timer", 32'(timer_sec), 32'd1);
        ticks(1);
        @(negedge clk);
        check("lit_fight_state", 32'(game_state), 32'd3);
        check("lit_fight_timer", 32'(timer_sec), 32'd60);
        check("lit_fight_ie", 32'(input_enable), 32'd1);
        start = 1'b1;
        cyc();
        cyc();
        start = 1'b0;
        @(negedge clk);
        check("lit_fight_press_ignored", 32'(game_state), 32'd3);
        ticks(25);
        @(negedge clk);
        check("lit_fight_timer59", 32'(timer_sec), 32'd59);
        health_2 = 9'd0;
        ticks(1);
        health_2 = 9'd100;
        @(negedge clk);
        check("lit_ko_state", 32'(game_state), 32'd4);
        check("lit_ko_wins1", 32'(wins_1), 32'd1);
        check("lit_ko_winner", 32'(winner), 32'd1);
        check("lit_ko_ie", 32'(input_enable), 32'd0);
        ticks(39);
        @(negedge clk);
        check("lit_hold_state", 32'(game_state), 32'd4);
        ticks(1);
        @(negedge clk);
        check("lit_r2_state", 32'(game_state), 32'd1);
        check("lit_r2_round", 32'(round_num), 32'd2);

        // Round 2: P1 KO again -> match over.
        ticks(60);
        health_2 = 9'd0;
        ticks(1);
        health_2 = 9'd100;
        ticks(40);
        @(negedge clk);
        check("lit_mo_state", 32'(game_state), 32'd5);
        check("lit_mo_wins1", 32'(wins_1), 32'd2);
        check("lit_mo_winner", 32'(winner), 32'd1);
        press_start();
        @(negedge clk);
        check("lit_back_idle", 32'(game_state), 32'd0);
        cyc();
        press_start();
        @(negedge clk);
        check("lit_new_state", 32'(game_state), 32'd1);
        check("lit_new_wins1", 32'(wins_1), 32'd0);
        check("lit_new_round", 32'(round_num), 32'd1);

        // Match 2, round 1: timer expiry with equal health -> draw.
        ticks(60);
        health_1 = 9'd50;
        health_2 = 9'd50;
        ticks(1199);
        @(negedge clk);
        check("lit_expiry_timer1", 32'(timer_sec), 32'd1);
        ticks(1);
        @(negedge clk);
        check("lit_expiry_state", 32'(game_state), 32'd4);
        check("lit_expiry_winner", 32'(winner), 32'd3);
        check("lit_expiry_wins", 32'({wins_1, wins_2}), 32'd0);
        ticks(40);
        @(negedge clk);
        check("lit_expiry_round", 32'(round_num), 32'd2);

        // Round 2: double KO -> draw.
        ticks(60);
        health_1 = 9'd0;
        health_2 = 9'd0;
        ticks(1);
        @(negedge clk);
        check("lit_dko_winner", 32'(winner), 32'd3);
        health_1 = 9'd100;
        health_2 = 9'd100;
        ticks(40);

        // Round 3: P2 wins.
        ticks(60);
        health_1 = 9'd0;
        health_2 = 9'd30;
        ticks(1);
        @(negedge clk);
        check("lit_p2_winner", 32'(winner), 32'd2);
        check("lit_p2_wins2", 32'(wins_2), 32'd1);
        health_1 = 9'd100;
        health_2 = 9'd100;
        ticks(40);

        // Round 4: reset in the middle of the fight.
        ticks(70);
        @(negedge clk);
        check("lit_r4_fight", 32'(game_state), 32'd3);
        check("lit_r4_round", 32'(round_num), 32'd4);
        cyc();
        reset = 1'b0;
        #1;
        check("lit_abort_state", 32'(game_state), 32'd0);
        check("lit_abort_timer", 32'(timer_sec), 32'd0);
        check("lit_abort_wins", 32'({wins_1, wins_2}), 32'd0);
        check("lit_abort_round", 32'(round_num), 32'd0);
        check("lit_abort_winner", 32'(winner), 32'd0);
        check("lit_abort_ie", 32'(input_enable), 32'd0);
        check("lit_abort_rr", 32'(round_reset), 32'd0);
        cyc();
        cyc();
        reset = 1'b1;
        repeat (5) cyc();
        @(negedge clk);
        check("lit_post_state", 32'(game_state), 32'd0);
        check("lit_post_rr", 32'(round_reset), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter TICKS_PER_SEC, default 20: game ticks per displayed second.
REQ-002 Parameter ROUND_SECONDS, default 60: round time limit in seconds.
REQ-003 Parameter COUNTDOWN_SECONDS, default 3: pre-fight countdown length in seconds.
REQ-004 Parameter KO_HOLD_TICKS, default 40: ticks held in ROUND_END before the next action.
REQ-005 Parameter WINS_TO_MATCH, default 2: round wins needed to take the match.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 tick  input  1  single-clk-cycle game-tick strobe (20 Hz), synchronous to clk.
REQ-009 start  input  1  start button level, already synchronous to clk.
REQ-010 health_1, health_2  input  9 each  current player health, unsigned.
REQ-011 game_state  output  3  current state encoding from the shared package.
REQ-012 input_enable  output  1  high only in FIGHT; gates both movement handlers.
REQ-013 round_reset  output  1  one-clk pulse commanding physics and health to reload their spawn values.
REQ-014 timer_sec  output  7  remaining seconds: countdown value in COUNTDOWN, round time in FIGHT.
REQ-015 wins_1, wins_2  output  2 each  rounds won per player.
REQ-016 round_num  output  3  current round number, 1-based, saturating at 7.
REQ-017 winner  output  2  0 = none, 1 = player 1, 2 = player 2, 3 = draw (last round result).

Function
REQ-018 States: IDLE, ROUND_INIT, COUNTDOWN, FIGHT, ROUND_END, MATCH_OVER.
REQ-019 All transitions occur on clk edges; timers advance only on cycles where tick=1.
REQ-020 Start press = rising edge of start (previous-cycle register); it is recognized on any clk cycle, not only tick cycles.
REQ-021 IDLE: on a start press, clear wins, set round_num=1 and winner=0, and go to ROUND_INIT.
REQ-022 ROUND_INIT: lasts exactly 1 clk cycle, asserts round_reset for that cycle, loads timer_sec=COUNTDOWN_SECONDS, then goes to COUNTDOWN.
REQ-023 COUNTDOWN: decrement timer_sec every TICKS_PER_SEC ticks; on the tick where timer_sec would reach 0, load ROUND_SECONDS and go to FIGHT.
REQ-024 FIGHT: decrement timer_sec every TICKS_PER_SEC ticks; health is evaluated only on tick cycles.
REQ-025 In FIGHT, round-end priority on a tick is: both health=0 -> draw; health_1=0 -> P2 wins; health_2=0 -> P1 wins; timer_sec reaching 0 -> the higher health wins, equal health -> draw.
REQ-026 On round end: the winner's wins counter increments (draw: no increment), winner is updated, the hold counter clears, and the state goes to ROUND_END.
REQ-027 ROUND_END: after KO_HOLD_TICKS ticks, go to MATCH_OVER if either wins counter equals WINS_TO_MATCH; otherwise increment round_num (saturating) and go to ROUND_INIT.
REQ-028 MATCH_OVER: hold wins and winner; a start press returns to IDLE.
REQ-029 A start press in any state other than IDLE or MATCH_OVER is ignored.
REQ-030 The prescaler clears on every state entry, so each displayed second lasts exactly TICKS_PER_SEC ticks.
REQ-031 round_reset is asserted in no state other than ROUND_INIT; input_enable is deasserted within 0 cycles of leaving FIGHT (combinational decode from state).

Reset
REQ-032 While reset=0: state=IDLE, timer_sec=0, wins_1=wins_2=0, round_num=0, winner=0, round_reset=0, prescaler=0, hold counter=0, start edge register=0.
REQ-033 Reset asserted mid-round aborts immediately; round_reset is not emitted until the next ROUND_INIT.

Structure
REQ-034 The shared package game_pkg holds the state enum/encoding, winner codes and default parameter constants.
REQ-035 One sub-module, sec_timer, holds the prescaler, loadable seconds down-counter and zero flag; it is instantiated once and shared by COUNTDOWN and FIGHT.

Verification
REQ-036 Reset, then start press -> ROUND_INIT for 1 cycle with round_reset=1; COUNTDOWN with timer_sec=3; FIGHT entered exactly 60 ticks later with timer_sec=60 and input_enable=1.
REQ-037 In FIGHT, health_2=0 on a tick -> wins_1=1, winner=1, ROUND_END; after 40 ticks -> ROUND_INIT with round_num=2.
REQ-038 Player 1 wins two rounds -> MATCH_OVER with wins_1=2 and winner=1; start press -> IDLE; a further start press clears wins to 0.
REQ-039 Timer expiry with health_1=health_2=50 -> winner=3, no wins change, round_num increments.
REQ-040 health_1=health_2=0 on the same tick -> draw; start pressed during FIGHT -> no effect; reset asserted mid-FIGHT -> IDLE with all outputs at reset values.
